// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback source, aligns/extends load data and drives the
// register-file write port from registers. Optional misaligned-load trap: WB_MISALIGN_CHECK_EN.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [XLEN-1:0]       in_load_data,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_en,
    output logic [XLEN-1:0]       wb_data,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic                  misalign_err
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    logic                  accept;
    logic [1:0]            off;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       load_val;
    logic [XLEN-1:0]       sel_val;
    logic                  misalign;

    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic                  wb_en_q, wb_en_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mis_q, mis_d;

    assign in_ready = ~hold;
    assign accept   = in_valid & ~hold & ~flush;
    assign off      = in_alu_result[1:0];

    always_comb begin
        ld_byte = 8'd0;
        case (off)
            2'd0: ld_byte = in_load_data[7:0];
            2'd1: ld_byte = in_load_data[15:8];
            2'd2: ld_byte = in_load_data[23:16];
            2'd3: ld_byte = in_load_data[31:24];
            default: ld_byte = 8'd0;
        endcase
        ld_half = off[1] ? in_load_data[31:16] : in_load_data[15:0];
    end

    // funct3[2] selects zero-extension (LBU/LHU); undefined codes fall through as a full word
    always_comb begin
        load_val = in_load_data;
        case (in_funct3)
            3'd0, 3'd4: load_val = {{(XLEN-8){ld_byte[7] & ~in_funct3[2]}}, ld_byte};
            3'd1, 3'd5: load_val = {{(XLEN-16){ld_half[15] & ~in_funct3[2]}}, ld_half};
            default:    load_val = in_load_data;
        endcase
    end

    always_comb begin
        sel_val = '0;
        case (in_wb_sel)
            SEL_ALU:  sel_val = in_alu_result;
            SEL_LOAD: sel_val = load_val;
            SEL_LINK: sel_val = in_pc_plus4;
            default:  sel_val = '0;
        endcase
    end

`ifdef WB_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (in_wb_sel == SEL_LOAD) begin
            case (in_funct3)
                3'd1, 3'd5: misalign = off[0];
                3'd2:       misalign = (off != 2'd0);
                default:    misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_en_d   = 1'b0;
        cnt_d     = cnt_q;
        mis_d     = 1'b0;
        if (accept) begin
            wb_addr_d = in_rd;
            wb_data_d = sel_val;
            wb_en_d   = in_reg_write & (in_rd != '0) & ~misalign;
            cnt_d     = cnt_q + 1'b1;
            mis_d     = misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_en_q   <= 1'b0;
            cnt_q     <= '0;
            mis_q     <= 1'b0;
        end else begin
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_en_q   <= wb_en_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
        end
    end

    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign wb_en        = wb_en_q;
    assign retired_cnt  = cnt_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table, hand-written corner sequences, then random traffic
// against a behavioural model. A narrow-counter instance checks wrap-around.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, hold, flush, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_pc_plus4, in_load_data;
    logic        in_ready, wb_en, misalign_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, retired_cnt;
    logic        in_ready_w, wb_en_w, misalign_err_w;
    logic [4:0]  wb_addr_w;
    logic [31:0] wb_data_w;
    logic [3:0]  retired_cnt_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
        .flush(flush), .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_load_data(in_load_data), .wb_addr(wb_addr), .wb_en(wb_en), .wb_data(wb_data),
        .retired_cnt(retired_cnt), .misalign_err(misalign_err)
    );

    wb_stage #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .hold(hold),
        .flush(flush), .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_load_data(in_load_data), .wb_addr(wb_addr_w), .wb_en(wb_en_w), .wb_data(wb_data_w),
        .retired_cnt(retired_cnt_w), .misalign_err(misalign_err_w)
    );

    // behavioural model state
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_cnt;
    logic        m_en, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] ld);
        int unsigned b, h;
        b = (ld >> (8 * off)) & 32'hFF;
        h = (ld >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return ld;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sel, input logic [2:0] f3,
                                           input logic [1:0] off);
`ifdef WB_MISALIGN_CHECK_EN
        if (sel != 2'd1) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 1;
        if (f3 == 3'd2) return off != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // advance one clock: model consumes current inputs, DUT sampled 1 time unit after the edge
    task automatic tick();
        logic        acc, mis;
        logic [31:0] val;
        acc = in_valid && !hold && !flush;
        mis = is_misaligned(in_wb_sel, in_funct3, in_alu_result[1:0]);
        case (in_wb_sel)
            2'd0:    val = in_alu_result;
            2'd1:    val = load_model(in_funct3, in_alu_result[1:0], in_load_data);
            2'd2:    val = in_pc_plus4;
            default: val = 32'd0;
        endcase
        if (rst) begin
            m_addr = 0; m_data = 0; m_en = 0; m_cnt = 0; m_mis = 0;
        end else if (acc) begin
            m_addr = in_rd;
            m_data = val;
            m_en   = in_reg_write && in_rd != 0 && !mis;
            m_mis  = mis;
            m_cnt  = m_cnt + 1;
        end else begin
            m_en  = 0;
            m_mis = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".en"},    {31'd0, wb_en},        {31'd0, m_en});
        chk({tag, ".addr"},  {27'd0, wb_addr},      {27'd0, m_addr});
        chk({tag, ".data"},  wb_data,               m_data);
        chk({tag, ".cnt"},   retired_cnt,           m_cnt);
        chk({tag, ".cnt_w"}, {28'd0, retired_cnt_w}, m_cnt % 16);
        chk({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    task automatic drive(input logic v, input logic h, input logic f, input logic rw,
                         input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] ld);
        in_valid = v; hold = h; flush = f; in_reg_write = rw; in_rd = rd;
        in_wb_sel = sel; in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc;
        in_load_data = ld;
    endtask

    typedef struct {
        logic        v, h, f, rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu, pc, ld;
        logic        e_ready, e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic h, input logic f, input logic rw,
                                input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] ld,
                                input logic e_en, input logic [4:0] e_addr,
                                input logic [31:0] e_data, input logic [31:0] e_cnt);
        vec_t t;
        t.v = v; t.h = h; t.f = f; t.rw = rw; t.rd = rd; t.sel = sel; t.f3 = f3;
        t.alu = alu; t.pc = pc; t.ld = ld; t.e_ready = !h; t.e_en = e_en;
        t.e_addr = e_addr; t.e_data = e_data; t.e_cnt = e_cnt;
        return t;
    endfunction

    vec_t tab[15];

    initial begin
        tab[0]  = mk(1,0,0,1, 5,0,0, 32'hDEADBEEF,0,0,            1, 5,32'hDEADBEEF, 1);
        tab[1]  = mk(1,0,0,1, 1,1,0, 32'h3,0,32'h80FF1234,        1, 1,32'hFFFFFF80, 2);
        tab[2]  = mk(1,0,0,1, 2,1,4, 32'h3,0,32'h80FF1234,        1, 2,32'h00000080, 3);
        tab[3]  = mk(1,0,0,1, 3,1,5, 32'h2,0,32'h80FF1234,        1, 3,32'h000080FF, 4);
        tab[4]  = mk(1,0,0,1, 4,1,1, 32'h0,0,32'h12348001,        1, 4,32'hFFFF8001, 5);
        tab[5]  = mk(1,0,0,1, 6,1,2, 32'h0,0,32'hCAFEF00D,        1, 6,32'hCAFEF00D, 6);
        tab[6]  = mk(1,0,0,1,31,2,0, 32'h0,32'h1004,0,            1,31,32'h00001004, 7);
        tab[7]  = mk(1,0,0,1, 8,3,0, 32'h55,32'h9,32'h9,          1, 8,32'h00000000, 8);
        tab[8]  = mk(1,0,0,1, 0,0,0, 32'h77,0,0,                  0, 0,32'h00000077, 9);
        tab[9]  = mk(1,0,1,1, 9,0,0, 32'h88,0,0,                  0, 0,32'h00000077, 9);
        tab[10] = mk(1,0,0,0,10,0,0, 32'h99,0,0,                  0,10,32'h00000099,10);
        tab[11] = mk(0,0,0,1,11,0,0, 32'hAA,0,0,                  0,10,32'h00000099,10);
        tab[12] = mk(1,0,0,1,12,1,7, 32'h1,0,32'h11223344,        1,12,32'h11223344,11);
        tab[13] = mk(1,0,0,1,13,1,4, 32'h1,0,32'h11223344,        1,13,32'h00000033,12);
        tab[14] = mk(1,1,1,1,14,0,0, 32'hBB,0,0,                  0,13,32'h00000033,12);

        drive(0,0,0,0,0,0,0,0,0,0);
        rst = 1;
        m_addr = 0; m_data = 0; m_en = 0; m_cnt = 0; m_mis = 0;
        @(posedge clk); #1;
        tick();
        rst = 0;
        check_model("reset");
        chk("reset.ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            drive(tab[i].v, tab[i].h, tab[i].f, tab[i].rw, tab[i].rd, tab[i].sel, tab[i].f3,
                  tab[i].alu, tab[i].pc, tab[i].ld);
            #1;
            chk($sformatf("tab%0d.ready", i), {31'd0, in_ready}, {31'd0, tab[i].e_ready});
            tick();
            chk($sformatf("tab%0d.en", i),   {31'd0, wb_en},   {31'd0, tab[i].e_en});
            chk($sformatf("tab%0d.addr", i), {27'd0, wb_addr}, {27'd0, tab[i].e_addr});
            chk($sformatf("tab%0d.data", i), wb_data,          tab[i].e_data);
            chk($sformatf("tab%0d.cnt", i),  retired_cnt,      tab[i].e_cnt);
        end

        // hold two cycles with a valid instruction, then release
        drive(1,1,0,1,20,0,0,32'hAB,0,0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold.ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("hold.en",   {31'd0, wb_en},   32'd0);
            chk("hold.addr", {27'd0, wb_addr}, 32'd13);
            chk("hold.data", wb_data,          32'h33);
        end
        hold = 0;
        tick();
        chk("release.en",   {31'd0, wb_en},   32'd1);
        chk("release.addr", {27'd0, wb_addr}, 32'd20);
        chk("release.data", wb_data,          32'hAB);
        chk("release.cnt",  retired_cnt,      32'd13);

        // misaligned word load
        drive(1,0,0,1,7,1,2,32'h102,0,32'h12345678);
        tick();
`ifdef WB_MISALIGN_CHECK_EN
        chk("mis.err", {31'd0, misalign_err}, 32'd1);
        chk("mis.en",  {31'd0, wb_en},        32'd0);
`else
        chk("mis.err", {31'd0, misalign_err}, 32'd0);
        chk("mis.en",  {31'd0, wb_en},        32'd1);
`endif
        chk("mis.cnt", retired_cnt, 32'd14);
        drive(0,0,0,0,0,0,0,0,0,0);
        tick();
        chk("mis.pulse", {31'd0, misalign_err}, 32'd0);
        check_model("mis.after");

        // reset mid-stream with a valid instruction presented
        drive(1,0,0,1,9,0,0,32'h1234,0,0);
        rst = 1;
        tick();
        rst = 0;
        chk("rst.en",   {31'd0, wb_en},   32'd0);
        chk("rst.addr", {27'd0, wb_addr}, 32'd0);
        chk("rst.data", wb_data,          32'd0);
        chk("rst.cnt",  retired_cnt,      32'd0);

        // narrow counter wraps 15 -> 0 while the wide one keeps going
        for (int i = 0; i < 15; i++) tick();
        chk("wrap.pre", {28'd0, retired_cnt_w}, 32'd15);
        tick();
        chk("wrap.zero", {28'd0, retired_cnt_w}, 32'd0);
        chk("wrap.wide", retired_cnt, 32'd16);
        check_model("wrap");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            rst = ($urandom_range(0, 49) == 0);
            #1;
            chk("rnd.ready", {31'd0, in_ready}, {31'd0, !hold});
            tick();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
